// File: rtl/x2dn_activity_sequencer_pkg.sv
// Shared types and widths for the x2dn activity sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package x2dn_seq_pkg;

    localparam int IN_W  = 82;
    localparam int OUT_W = 56;
    localparam int TOG_W = 6;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        OUTPUT  = 2'd3
    } state_e;

endpackage

// File: rtl/x2dn_activity_sequencer_if.sv
// Stimulus-in / result-out handshake bundle of the activity sequencer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the stimulus and result channels.
interface x2dn_activity_sequencer_if;
    import x2dn_seq_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_vec;
    logic              res_valid;
    logic              res_ready;
    logic [OUT_W-1:0]  res_vec;
    logic [TOG_W-1:0]  res_toggles;

    // Stimulus producer / result consumer side.
    modport master (
        output in_valid, in_vec, res_ready,
        input  in_ready, res_valid, res_vec, res_toggles
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_vec, res_ready,
        output in_ready, res_valid, res_vec, res_toggles
    );

endinterface

// File: rtl/x2dn_activity_sequencer_popcount56.sv
// Population count of a 56-bit vector.
// Latency: combinational.
// Backpressure: none.
module popcount56
    import x2dn_seq_pkg::*;
(
    input  logic [OUT_W-1:0] i_vec,
    output logic [TOG_W-1:0] o_cnt
);

    // Ones counter; 56 fits in 6 bits with headroom.
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < OUT_W; i++) begin
            o_cnt = o_cnt + TOG_W'(i_vec[i]);
        end
    end

endmodule

// File: rtl/x2dn_activity_sequencer.sv
// Drives stimulus into the external x2dn block, samples its response, tracks toggle activity.
// Latency: accept at T, result valid from T+SETTLE_CYCLES+2; one vector per SETTLE_CYCLES+3 cycles.
// Backpressure: in_ready only in IDLE; result held in OUTPUT until res_ready.
module x2dn_activity_sequencer
    import x2dn_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ACC_W         = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    x2dn_activity_sequencer_if.slave bus,
    output logic [IN_W-1:0]          dut_in,
    input  logic [OUT_W-1:0]         dut_out,
    output logic [ACC_W-1:0]         acc_toggles,
    output logic [CNT_W-1:0]         vec_count,
    input  logic                     clear
);

    localparam int SET_W = 4;

    state_e             r_state;
    state_e             w_next;
    logic [SET_W-1:0]   r_settle;
    logic [IN_W-1:0]    r_dut_in;
    logic [OUT_W-1:0]   r_prev;
    logic [OUT_W-1:0]   r_res_vec;
    logic [TOG_W-1:0]   r_res_tog;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_vcnt;
    logic [OUT_W-1:0]   w_diff;
    logic [TOG_W-1:0]   w_tog;
    logic [ACC_W:0]     w_sum;
    logic               w_accept;
    logic               w_capture;
    logic               w_in_ready;
    logic               w_res_valid;

    assign w_diff = dut_out ^ r_prev;

    popcount56 u_popcount (
        .i_vec (w_diff),
        .o_cnt (w_tog)
    );

    // One extra bit catches the carry out so the accumulator can clamp.
    assign w_sum = {1'b0, r_acc} + (ACC_W + 1)'(w_tog);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and strobes; handshake outputs decode state only.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_in_ready  = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = SETTLE;
                end
            end
            SETTLE: begin
                if (r_settle == '0) begin
                    w_next = CAPTURE;
                end
            end
            CAPTURE: begin
                w_capture = 1'b1;
                w_next    = OUTPUT;
            end
            OUTPUT: begin
                w_res_valid = 1'b1;
                if (bus.res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Stimulus register loads only on accept; settle counter runs down in SETTLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dut_in <= '0;
            r_settle <= '0;
        end else if (w_accept) begin
            r_dut_in <= bus.in_vec;
            r_settle <= SET_W'(SETTLE_CYCLES - 1);
        end else if (r_state == SETTLE && r_settle != '0) begin
            r_settle <= r_settle - SET_W'(1);
        end
    end

    // Reported result is unaffected by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_vec <= '0;
            r_res_tog <= '0;
        end else if (w_capture) begin
            r_res_vec <= dut_out;
            r_res_tog <= w_tog;
        end
    end

    // Statistics; clear beats a coincident capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_acc  <= '0;
            r_vcnt <= '0;
        end else if (clear) begin
            r_prev <= '0;
            r_acc  <= '0;
            r_vcnt <= '0;
        end else if (w_capture) begin
            r_prev <= dut_out;
            r_acc  <= w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
            r_vcnt <= r_vcnt + CNT_W'(1);
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.res_valid   = w_res_valid;
    assign bus.res_vec     = r_res_vec;
    assign bus.res_toggles = r_res_tog;
    assign dut_in          = r_dut_in;
    assign acc_toggles     = r_acc;
    assign vec_count       = r_vcnt;

endmodule

// File: tb/tb_x2dn_activity_sequencer.sv
// Randomised bench with a behavioural model and a stand-in x2dn response function.
// Latency: n/a.
// Backpressure: exercises res_ready stalls and pending in_valid.
module tb_x2dn_activity_sequencer;

    localparam int S       = 2;
    localparam int AW      = 10;
    localparam int unsigned MAXACC = (1 << AW) - 1;
    localparam logic [55:0] BASE0 = 56'h10_8100_0110;  // bits 4,8,24,31,36

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic [81:0]   dut_in;
    logic [55:0]   dut_out;
    logic [AW-1:0] acc_toggles;
    logic [15:0]   vec_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit run   = 0;

    logic [81:0] last_v = '0;

    x2dn_activity_sequencer_if bus ();

    x2dn_activity_sequencer #(.SETTLE_CYCLES(S), .ACC_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dut_in      (dut_in),
        .dut_out     (dut_out),
        .acc_toggles (acc_toggles),
        .vec_count   (vec_count),
        .clear       (clear)
    );

    // Stand-in for the external combinational x2dn block: zero input gives
    // bits 4,8,24,31,36; v4 alone flips bits 3,8,9; other inputs mix in linearly.
    function automatic logic [55:0] x2dn(input logic [81:0] v);
        logic [55:0] o;
        o = BASE0;
        if (v[4]) o = o ^ 56'h0000_0000_0308;
        o = o ^ v[81:26] ^ {31'b0, v[25:5], v[3:0]};
        return o;
    endfunction

    assign dut_out = x2dn(dut_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_k counts edges since the accept: result appears S+2 edges later,
    // statistics change on the edge that makes it appear.
    bit            m_busy = 0;
    int            m_k    = 0;
    logic [81:0]   m_din  = '0;
    logic [55:0]   m_prev = '0;
    logic [55:0]   m_rvec = '0;
    int unsigned   m_rtog = 0;
    int unsigned   m_acc  = 0;
    logic [15:0]   m_cnt  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_k = 0; m_din = '0; m_prev = '0;
            m_rvec = '0; m_rtog = 0; m_acc = 0; m_cnt = '0;
        end else begin
            logic [55:0] o;
            int unsigned s;
            if (m_busy && m_k == S + 1) begin
                o      = x2dn(m_din);
                m_rvec = o;
                m_rtog = $countones(o ^ m_prev);
                if (clear) begin
                    m_prev = '0; m_acc = 0; m_cnt = '0;
                end else begin
                    m_prev = o;
                    m_cnt  = m_cnt + 16'd1;
                    s      = m_acc + m_rtog;
                    m_acc  = (s > MAXACC) ? MAXACC : s;
                end
                m_k++;
            end else begin
                if (clear) begin
                    m_prev = '0; m_acc = 0; m_cnt = '0;
                end
                if (m_busy && m_k >= S + 2) begin
                    if (bus.res_ready) m_busy = 0;
                end else if (m_busy) begin
                    m_k++;
                end else if (bus.in_valid) begin
                    m_busy = 1; m_k = 1; m_din = bus.in_vec;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("in_ready",    bus.in_ready,  !m_busy);
            chk("res_valid",   bus.res_valid, m_busy && m_k >= S + 2);
            chk("dut_in",      dut_in,        m_din);
            chk("res_vec",     bus.res_vec,   m_rvec);
            chk("res_toggles", bus.res_toggles, m_rtog);
            chk("acc_toggles", acc_toggles,   m_acc);
            chk("vec_count",   vec_count,     m_cnt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic rnd_vec(output logic [81:0] v);
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        v = r[81:0];
    endtask

    task automatic send(input logic [81:0] v, input int hold, input bit pend,
                        input bit clr_cap, output int lat);
        int n;
        int c0;
        lat = -1;
        bus.in_vec   = v;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        c0 = cyc;
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        last_v = v;
        if (clr_cap) begin
            @(posedge clk); #2;
            @(posedge clk); #2;
            clear = 1'b1;
            @(posedge clk); #2;
            clear = 1'b0;
        end
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.res_valid) begin
            chk("result_timeout", 0, 1);
            return;
        end
        lat = cyc - c0;
        if (pend) begin
            bus.in_valid = 1'b1;
            bus.in_vec   = ~v;
        end
        repeat (hold) @(negedge clk);
        if (pend) begin
            chk("stall_in_ready",  bus.in_ready, 0);
            chk("stall_res_valid", bus.res_valid, 1);
            chk("stall_dut_in",    dut_in, v);
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #2;
        bus.res_ready = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    task automatic gap();
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        int lat;
        logic [81:0] v;
        logic [81:0] pv;
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_vec    = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  bus.in_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_dut_in",    dut_in, 0);
        chk("rst_acc",       acc_toggles, 0);
        chk("rst_vcnt",      vec_count, 0);
        #1;
        rst_n = 1'b1;
        run   = 1;
        @(posedge clk); #2;

        // Zero vector from reset: five bits set against prev 0.
        send('0, 0, 0, 0, lat);
        chk("lat_first",  lat, 4);
        chk("v0_res_vec", bus.res_vec, 56'h10_8100_0110);
        chk("v0_tog",     bus.res_toggles, 5);
        chk("v0_acc",     acc_toggles, 5);
        chk("v0_cnt",     vec_count, 1);

        send('0, 0, 0, 0, lat);
        chk("v1_tog", bus.res_toggles, 0);
        chk("v1_acc", acc_toggles, 5);
        chk("v1_cnt", vec_count, 2);

        // v4 only, with a 10-cycle result stall and a pending stimulus.
        v = '0;
        v[4] = 1'b1;
        send(v, 10, 1, 0, lat);
        chk("v4_res_vec", bus.res_vec, 56'h10_8100_0218);
        chk("v4_tog",     bus.res_toggles, 3);
        chk("v4_acc",     acc_toggles, 8);
        chk("v4_cnt",     vec_count, 3);

        // Random traffic without clears drives the narrow accumulator to its ceiling.
        for (int i = 0; i < 60; i++) begin
            rnd_vec(v);
            gap();
            send(v, $urandom_range(0, 2), 0, 0, lat);
        end
        chk("sat_acc", acc_toggles, 10'h3FF);
        v = '0;
        send(v, 0, 0, 0, lat);
        chk("sat_hold", acc_toggles, 10'h3FF);

        // Clear coincident with capture: result reported, statistics zeroed.
        pv = last_v;
        rnd_vec(v);
        send(v, 0, 0, 1, lat);
        chk("clrcap_acc", acc_toggles, 0);
        chk("clrcap_cnt", vec_count, 0);
        chk("clrcap_tog", bus.res_toggles, $countones(x2dn(v) ^ x2dn(pv)));

        send('0, 0, 0, 0, lat);
        chk("postclr_tog", bus.res_toggles, 5);
        chk("postclr_acc", acc_toggles, 5);
        chk("postclr_cnt", vec_count, 1);

        // Random traffic with occasional clears during capture.
        for (int i = 0; i < 30; i++) begin
            rnd_vec(v);
            gap();
            send(v, $urandom_range(0, 3), 0, ($urandom_range(0, 5) == 0), lat);
        end

        // Reset in the middle of SETTLE.
        rnd_vec(v);
        bus.in_vec   = v;
        bus.in_valid = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.in_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("midrst_accept", bus.in_ready, 1);
        end
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready",  bus.in_ready, 1);
        chk("midrst_res_valid", bus.res_valid, 0);
        chk("midrst_dut_in",    dut_in, 0);
        chk("midrst_acc",       acc_toggles, 0);
        chk("midrst_cnt",       vec_count, 0);
        chk("midrst_tog",       bus.res_toggles, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        send('0, 0, 0, 0, lat);
        chk("afterrst_tog", bus.res_toggles, 5);
        chk("afterrst_acc", acc_toggles, 5);
        chk("afterrst_cnt", vec_count, 1);

        run = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/x2dn_activity_sequencer.md
X2DN_ACTIVITY_SEQUENCER -- requirements
Module: x2dn_activity_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, range 1..15: cycles dut_in is held before dut_out is sampled.
REQ-002 SHALL have parameter ACC_W, default 32: width of the saturating toggle accumulator.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  stimulus vector offered.
REQ-006 in_ready  output  1  sequencer accepts a vector this cycle.
REQ-007 in_vec  input  82  stimulus; bit i = x2dn input vi.
REQ-008 dut_in  output  82  registered drive to the x2dn combinational block.
REQ-009 dut_out  input  56  x2dn response; bit j = output v82.j.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer takes the result.
REQ-012 res_vec  output  56  captured dut_out.
REQ-013 res_toggles  output  6  popcount(captured dut_out XOR previous captured dut_out).
REQ-014 acc_toggles  output  ACC_W  running sum of res_toggles, saturating.
REQ-015 vec_count  output  16  vectors captured, wraps.
REQ-016 clear  input  1  synchronous clear of the statistics.

Function
REQ-017 SHALL implement FSM states IDLE, SETTLE, CAPTURE, OUTPUT.
REQ-018 IDLE: in_ready=1; on in_valid, load dut_in<=in_vec and settle counter<=SETTLE_CYCLES-1, go to SETTLE.
REQ-019 in_ready SHALL be 1 only in IDLE and SHALL NOT depend combinationally on any input.
REQ-020 SETTLE: decrement counter each cycle; at counter 0, go to CAPTURE (SETTLE lasts exactly SETTLE_CYCLES cycles).
REQ-021 CAPTURE (one cycle): res_vec<=dut_out; res_toggles<=popcount(dut_out^prev_out); prev_out<=dut_out; acc_toggles+=toggles; vec_count+=1; go to OUTPUT.
REQ-022 OUTPUT: res_valid=1; res_vec and res_toggles stable until res_ready=1, then go to IDLE.
REQ-023 Latency: accept in cycle T, first cycle with res_valid=1 is T+SETTLE_CYCLES+2; back-to-back throughput is one vector per SETTLE_CYCLES+3 cycles.
REQ-024 dut_in SHALL change only on an accept edge and hold between accepts.
REQ-025 acc_toggles SHALL saturate at 2^ACC_W-1 and never wrap; vec_count SHALL wrap from 0xFFFF to 0.
REQ-026 clear=1 SHALL zero acc_toggles, vec_count and prev_out on the next edge; FSM, dut_in, res_vec and res_toggles are unaffected.
REQ-027 clear coincident with CAPTURE: res_vec/res_toggles update normally; clear wins for acc_toggles, vec_count and prev_out (all 0).
REQ-028 The first vector after reset or clear SHALL compare against prev_out=0.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE; counter, dut_in, prev_out, res_vec, res_toggles, acc_toggles and vec_count all 0.
REQ-030 Reset outputs: in_ready=1, res_valid=0.
REQ-031 Reset in any state SHALL abort the vector in progress with no partial statistics update.

Structure
REQ-032 Package x2dn_seq_pkg SHALL hold: state enum, IN_W=82, OUT_W=56, TOG_W=6, CNT_W=16.
REQ-033 Sub-module popcount56 (56-bit in, 6-bit count, combinational) SHALL compute toggles.
REQ-034 The x2dn combinational block SHALL be instantiated outside this module, between dut_in and dut_out.

Verification (x2dn connected, SETTLE_CYCLES=2)
REQ-035 Reset, then in_vec=0 accepted at T: res_valid first at T+4; res_vec has exactly bits 4,8,24,31,36 set; res_toggles=5, acc_toggles=5, vec_count=1.
REQ-036 Then in_vec=0 again: res_toggles=0, acc_toggles=5, vec_count=2.
REQ-037 Then in_vec with only v4=1: bit 8 clears, bits 3 and 9 set; res_toggles=3, acc_toggles=8.
REQ-038 Hold res_ready=0 for 10 cycles in OUTPUT: res_valid stays 1, res_vec stable, in_ready=0, a pending in_valid is not accepted.
REQ-039 Preload acc_toggles to 2^32-2, capture a vector with 5 toggles: acc_toggles=0xFFFFFFFF; clear during CAPTURE: acc_toggles=0, vec_count=0, res_toggles still reported.
REQ-040 Assert rst_n=0 mid-SETTLE: outputs immediately at reset values; the next vector reports toggles against 0.
